// File: rtl/rib_xbar.sv
// rib_xbar: N-master / N-slave RIB interconnect with a single shared path.
// Arbitrates the masters, decodes addr[AW-1 -: 4] to a slave, and locks the path
// while a slave stalls. It returns an error for decode misses and for stalls that
// reach TIMEOUT cycles.
// Optional feature: define RIB_RR_EN for round-robin arbitration. When it is not
// defined, arbitration is fixed priority and the highest index wins.
module rib_xbar #(
    parameter int         N_MASTERS = 4,
    parameter int         N_SLAVES  = 8,
    parameter int         AW        = 32,
    parameter int         DW        = 32,
    parameter int         TIMEOUT   = 255,
    parameter logic [7:0] HOLD_MASK = 8'b0000_1101
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS*AW-1:0] m_addr_i,
    input  logic [N_MASTERS*DW-1:0] m_data_i,
    input  logic [N_MASTERS-1:0]    m_we_i,
    input  logic [N_MASTERS-1:0]    m_req_i,
    output logic [N_MASTERS*DW-1:0] m_data_o,
    output logic [N_MASTERS-1:0]    m_ready_o,
    output logic [N_MASTERS-1:0]    m_err_o,
    output logic [N_SLAVES*AW-1:0]  s_addr_o,
    output logic [N_SLAVES*DW-1:0]  s_data_o,
    input  logic [N_SLAVES*DW-1:0]  s_data_i,
    output logic [N_SLAVES-1:0]     s_we_o,
    output logic [N_SLAVES-1:0]     s_req_o,
    input  logic [N_SLAVES-1:0]     s_ready_i,
    output logic                    hold_flag_o
);
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state;
    logic [MW-1:0]   r_gnt;
    logic [CW-1:0]   r_cnt;
`ifdef RIB_RR_EN
    logic [MW-1:0]   r_rr_ptr;
`endif

    logic [MW-1:0]   w_win;
    logic            w_any_req;
    logic            w_busy;
    logic [MW-1:0]   w_sel;
    logic            w_active;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic            w_we;
    logic [3:0]      w_sidx;
    logic            w_hit;
    logic            w_srdy;
    logic [DW-1:0]   w_rdata;
    logic            w_tmo;
    logic            w_ok;
    logic            w_err;
    logic            w_done;
    logic            w_hold_gnt;

    // Pick the arbitration winner among the requesting masters (used only in IDLE)
    always_comb begin
        w_win     = '0;
        w_any_req = |m_req_i;
`ifdef RIB_RR_EN
        // Later assignments override earlier ones. The result is the lowest
        // requester above the pointer, or the lowest requester at or below it.
        for (int m = N_MASTERS - 1; m >= 0; m--) begin
            if (m_req_i[m] && (MW'(m) <= r_rr_ptr)) w_win = MW'(m);
        end
        for (int m = N_MASTERS - 1; m >= 0; m--) begin
            if (m_req_i[m] && (MW'(m) > r_rr_ptr)) w_win = MW'(m);
        end
`else
        for (int m = 0; m < N_MASTERS; m++) begin
            if (m_req_i[m]) w_win = MW'(m);
        end
`endif
    end

    // Select the active master, decode its slave, and classify the cycle's outcome
    always_comb begin
        w_busy     = (r_state == S_BUSY);
        w_sel      = w_busy ? r_gnt : w_win;
        w_active   = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        w_we       = 1'b0;
        w_hold_gnt = 1'b0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (MW'(m) == w_sel) begin
                w_active = w_busy ? m_req_i[m] : w_any_req;
                w_addr   = m_addr_i[m*AW +: AW];
                w_wdata  = m_data_i[m*DW +: DW];
                w_we     = m_we_i[m];
            end
            if (MW'(m) == r_gnt) w_hold_gnt = HOLD_MASK[m];
        end
        w_sidx  = w_addr[AW-1 -: 4];
        w_hit   = ({1'b0, w_sidx} < 5'(N_SLAVES));
        w_srdy  = 1'b0;
        w_rdata = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            if (w_sidx == 4'(s)) begin
                w_srdy  = s_ready_i[s];
                w_rdata = s_data_i[s*DW +: DW];
            end
        end
        w_tmo  = w_busy && (r_cnt == CW'(TIMEOUT));
        // A ready slave beats the watchdog when both happen in the same cycle
        w_ok   = w_active && w_hit && w_srdy;
        w_err  = w_active && (!w_hit || (w_tmo && !w_srdy));
        w_done = w_ok || w_err;
    end

    // Drive slave and master ports from the selected path; everything is quiet in reset
    always_comb begin
        s_req_o     = '0;
        s_we_o      = '0;
        s_addr_o    = '0;
        s_data_o    = '0;
        m_ready_o   = '0;
        m_err_o     = '0;
        m_data_o    = '0;
        hold_flag_o = 1'b0;
        if (!rst) begin
            for (int s = 0; s < N_SLAVES; s++) begin
                if (w_active && (w_sidx == 4'(s))) begin
                    s_req_o[s]             = 1'b1;
                    s_we_o[s]              = w_we;
                    s_addr_o[s*AW +: AW]   = w_addr;
                    s_data_o[s*DW +: DW]   = w_wdata;
                end
            end
            for (int m = 0; m < N_MASTERS; m++) begin
                if (w_done && (MW'(m) == w_sel)) begin
                    m_ready_o[m]         = 1'b1;
                    m_err_o[m]           = w_err;
                    m_data_o[m*DW +: DW] = w_ok ? w_rdata : '0;
                end
            end
            hold_flag_o = (|(m_req_i & HOLD_MASK[N_MASTERS-1:0])) || (w_busy && w_hold_gnt);
        end
    end

    // IDLE/BUSY control: lock the grant while the slave stalls and run the watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_active && !w_done) begin
                        r_state <= S_BUSY;
                        r_gnt   <= w_win;
                        r_cnt   <= CW'(1);
                    end
                end
                S_BUSY: begin
                    if (!w_active || w_done) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != CW'(TIMEOUT)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RIB_RR_EN
    // Move the round-robin pointer to the last master that completed (aborts do not count)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= MW'(N_MASTERS - 1);
        end else if (w_done) begin
            r_rr_ptr <= w_sel;
        end
    end
`endif

endmodule

// File: tb/tb_rib_xbar.sv
// tb_rib_xbar: directed bench for rib_xbar with an expected-response scoreboard.
// Uses TIMEOUT=4 so the watchdog paths stay short. The priority step follows
// RIB_RR_EN when that macro is defined.
module tb_rib_xbar;
    localparam int NM  = 4;
    localparam int NS  = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NM*AW-1:0]   m_addr_i;
    logic [NM*DW-1:0]   m_data_i;
    logic [NM-1:0]      m_we_i;
    logic [NM-1:0]      m_req_i;
    logic [NM*DW-1:0]   m_data_o;
    logic [NM-1:0]      m_ready_o;
    logic [NM-1:0]      m_err_o;
    logic [NS*AW-1:0]   s_addr_o;
    logic [NS*DW-1:0]   s_data_o;
    logic [NS*DW-1:0]   s_data_i;
    logic [NS-1:0]      s_we_o;
    logic [NS-1:0]      s_req_o;
    logic [NS-1:0]      s_ready_i;
    logic               hold_flag_o;

    rib_xbar #(
        .N_MASTERS(NM), .N_SLAVES(NS), .AW(AW), .DW(DW),
        .TIMEOUT(TMO), .HOLD_MASK(8'b0000_1101)
    ) dut (
        .clk(clk), .rst(rst),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_we_i(m_we_i), .m_req_i(m_req_i),
        .m_data_o(m_data_o), .m_ready_o(m_ready_o), .m_err_o(m_err_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_we_o(s_we_o), .s_req_o(s_req_o), .s_ready_i(s_ready_i),
        .hold_flag_o(hold_flag_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            m;
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [NS*AW-1:0] exp_saddr;
    logic [NS*DW-1:0] exp_sdata;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int m, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.m = m; x.d = d; x.e = e;
        sb.push_back(x);
    endtask

    // Check ready against the cycle's expectation; on any ready, pop and check err/data
    task automatic chk_resp(input string tag, input logic [NM-1:0] rdy);
        exp_t             x;
        logic [NM*DW-1:0] xd;
        logic [NM-1:0]    xe;
        chk({tag, "/ready"}, 256'(m_ready_o), 256'(rdy));
        xd = '0;
        xe = '0;
        if (m_ready_o !== '0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL %s/sb observed ready=%b expected no response", tag, m_ready_o);
                return;
            end
            x = sb.pop_front();
            xd[x.m*DW +: DW] = x.d;
            xe[x.m] = x.e;
        end
        chk({tag, "/err"},  256'(m_err_o),  256'(xe));
        chk({tag, "/data"}, 256'(m_data_o), 256'(xd));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mreq(input int m, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
        m_addr_i[m*AW +: AW] = a;
        m_data_i[m*DW +: DW] = d;
        m_we_i[m]  = we;
        m_req_i[m] = 1'b1;
    endtask

    task automatic mdrop(input int m);
        m_req_i[m] = 1'b0;
        m_we_i[m]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int pm;
        rst = 1'b1;
        m_addr_i = '0; m_data_i = '0; m_we_i = '0; m_req_i = '0;
        s_ready_i = '1;
        for (int s = 0; s < NS; s++) s_data_i[s*DW +: DW] = 32'hA000_0000 + 32'(s);
        s_data_i[1*DW +: DW] = 32'hDEAD_BEEF;
        step();

        // Reset: every master requesting, all outputs must stay 0
        for (int m = 0; m < NM; m++) mreq(m, 32'h1000_0000, 1'b1, 32'h5555_0000);
        #1;
        chk("rst/s_req",  256'(s_req_o),  256'(0));
        chk("rst/s_we",   256'(s_we_o),   256'(0));
        chk("rst/s_addr", 256'(s_addr_o), 256'(0));
        chk("rst/hold",   256'(hold_flag_o), 256'(0));
        chk_resp("rst", 4'b0000);
        step();
        rst = 1'b0; m_req_i = '0; m_we_i = '0;
        step();

        // Zero-wait read by m1 from slave 1
        mreq(1, 32'h1000_0040, 1'b0, 32'h0);
        push(1, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("zw/s_req",   256'(s_req_o), 256'(8'h02));
        chk("zw/s_addr1", 256'(s_addr_o[1*AW +: AW]), 256'(32'h1000_0040));
        chk("zw/s_we",    256'(s_we_o), 256'(0));
        chk("zw/hold",    256'(hold_flag_o), 256'(0));
        chk_resp("zw", 4'b0010);
        step();
        // Still IDLE: a new master is served at once
        mdrop(1);
        mreq(3, 32'h3000_0000, 1'b0, 32'h0);
        push(3, 32'hA000_0003, 1'b0);
        #1;
        chk_resp("zw/next", 4'b1000);
        step();
        mdrop(3);

        // Lock: slave 6 stalls 3 cycles, m3 arrives in cycle 2 and must wait
        s_ready_i[6] = 1'b0;
        s_data_i[6*DW +: DW] = 32'h6666_0006;
        mreq(0, 32'h6000_0000, 1'b0, 32'h0);
        #1;
        chk("lock/c1/s_req", 256'(s_req_o), 256'(8'h40));
        chk("lock/c1/hold",  256'(hold_flag_o), 256'(1));
        chk_resp("lock/c1", 4'b0000);
        step();
        mreq(3, 32'h3000_0010, 1'b0, 32'h0);
        #1;
        chk("lock/c2/s_req",  256'(s_req_o), 256'(8'h40));
        chk("lock/c2/s_addr", 256'(s_addr_o[6*AW +: AW]), 256'(32'h6000_0000));
        chk_resp("lock/c2", 4'b0000);
        step();
        #1;
        chk("lock/c3/s_req", 256'(s_req_o), 256'(8'h40));
        chk_resp("lock/c3", 4'b0000);
        step();
        s_ready_i[6] = 1'b1;
        push(0, 32'h6666_0006, 1'b0);
        #1;
        chk("lock/c4/s_addr", 256'(s_addr_o[6*AW +: AW]), 256'(32'h6000_0000));
        chk_resp("lock/c4", 4'b0001);
        step();
        mdrop(0);
        push(3, 32'hA000_0003, 1'b0);
        #1;
        chk("lock/c5/s_req",  256'(s_req_o), 256'(8'h08));
        chk("lock/c5/s_addr", 256'(s_addr_o[3*AW +: AW]), 256'(32'h3000_0010));
        chk_resp("lock/c5", 4'b1000);
        step();
        mdrop(3);

        // Timeout: slave 7 never ready, error on the 4th BUSY cycle
        s_ready_i[7] = 1'b0;
        mreq(2, 32'h7000_0000, 1'b0, 32'h0);
        #1;
        chk("tmo/hold", 256'(hold_flag_o), 256'(1));
        chk_resp("tmo/idle", 4'b0000);
        for (int b = 1; b <= TMO - 1; b++) begin
            step();
            #1;
            chk("tmo/busy/s_req", 256'(s_req_o), 256'(8'h80));
            chk_resp("tmo/busy", 4'b0000);
        end
        step();
        push(2, 32'h0, 1'b1);
        #1;
        chk("tmo/exp/s_req", 256'(s_req_o), 256'(8'h80));
        chk_resp("tmo/exp", 4'b0100);
        step();
        mdrop(2);
        mreq(3, 32'h3000_0000, 1'b0, 32'h0);
        push(3, 32'hA000_0003, 1'b0);
        #1;
        chk_resp("tmo/after", 4'b1000);
        step();
        mdrop(3);

        // Ready arriving in the timeout cycle wins, no error
        mreq(2, 32'h7000_0000, 1'b0, 32'h0);
        #1;
        chk_resp("rt/idle", 4'b0000);
        for (int b = 1; b <= TMO - 1; b++) begin
            step();
            #1;
            chk_resp("rt/busy", 4'b0000);
        end
        step();
        s_ready_i[7] = 1'b1;
        push(2, 32'hA000_0007, 1'b0);
        #1;
        chk_resp("rt/last", 4'b0100);
        step();
        mdrop(2);

        // Decode miss: write to slave index 9 has no slave side effect
        mreq(0, 32'h9000_0000, 1'b1, 32'h1234_5678);
        push(0, 32'h0, 1'b1);
        #1;
        chk("miss/s_we",   256'(s_we_o),   256'(0));
        chk("miss/s_req",  256'(s_req_o),  256'(0));
        chk("miss/s_data", 256'(s_data_o), 256'(0));
        chk_resp("miss", 4'b0001);
        step();
        mdrop(0);

        // Write routing: only slave 2 sees address/data/we
        mreq(3, 32'h2000_0004, 1'b1, 32'hCAFE_F00D);
        push(3, 32'hA000_0002, 1'b0);
        exp_saddr = '0; exp_saddr[2*AW +: AW] = 32'h2000_0004;
        exp_sdata = '0; exp_sdata[2*DW +: DW] = 32'hCAFE_F00D;
        #1;
        chk("wr/s_we",   256'(s_we_o), 256'(8'h04));
        chk("wr/s_addr", 256'(s_addr_o), 256'(exp_saddr));
        chk("wr/s_data", 256'(s_data_o), 256'(exp_sdata));
        chk_resp("wr", 4'b1000);
        step();
        mdrop(3);

        // Abort: m1 drops its request while BUSY
        s_ready_i[5] = 1'b0;
        mreq(1, 32'h5000_0000, 1'b0, 32'h0);
        #1;
        chk_resp("abort/idle", 4'b0000);
        step();
        #1;
        chk("abort/busy/s_req", 256'(s_req_o), 256'(8'h20));
        chk_resp("abort/busy", 4'b0000);
        step();
        mdrop(1);
        #1;
        chk("abort/drop/s_req", 256'(s_req_o), 256'(0));
        chk_resp("abort/drop", 4'b0000);
        step();
        mreq(3, 32'h3000_0000, 1'b0, 32'h0);
        push(3, 32'hA000_0003, 1'b0);
        #1;
        chk_resp("abort/after", 4'b1000);
        step();
        mdrop(3);

        // Reset while BUSY: outputs 0, transfer dropped, IDLE afterwards
        mreq(1, 32'h5000_0000, 1'b0, 32'h0);
        #1;
        chk_resp("rb/idle", 4'b0000);
        step();
        #1;
        chk_resp("rb/busy", 4'b0000);
        step();
        rst = 1'b1;
        #1;
        chk("rb/rst/s_req", 256'(s_req_o), 256'(0));
        chk("rb/rst/hold",  256'(hold_flag_o), 256'(0));
        chk_resp("rb/rst", 4'b0000);
        step();
        rst = 1'b0;
        mdrop(1);
        mreq(3, 32'h3000_0000, 1'b0, 32'h0);
        push(3, 32'hA000_0003, 1'b0);
        #1;
        chk_resp("rb/after", 4'b1000);
        step();
        mdrop(3);

        // Priority: fresh reset, all masters request, all slaves ready
        s_ready_i = '1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int m = 0; m < NM; m++) mreq(m, AW'(m) << (AW - 4), 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
`ifdef RIB_RR_EN
            pm = k % NM;
`else
            pm = NM - 1;
`endif
            push(pm, 32'hA000_0000 + 32'(pm), 1'b0);
            #1;
            chk_resp("prio", NM'(1) << pm);
            step();
        end
        m_req_i = '0;

        chk("sb/drain", 256'(sb.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
